// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide sequencer.
// Holds op codes, the sequencer state encoding, the ALU control codes shared with
// the main ALU decoder, and the iteration count for one MUL/DIV pass.
package mdu_pkg;

    // op[0] selects divide, op[1] selects signed (when signed support is built in)
    localparam logic [1:0] OP_MULTU = 2'd0;
    localparam logic [1:0] OP_DIVU  = 2'd1;
    localparam logic [1:0] OP_MULT  = 2'd2;
    localparam logic [1:0] OP_DIV   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_SLL = 4'd2;
    localparam logic [3:0] ALU_ADD = 4'd4;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: signed-operation helper for mdu_seq (built only with MDU_SIGNED_EN).
// Latency: purely combinational. Backpressure: none, no handshake.
// Ports: a_in/b_in -> a_mag/b_mag plus sign flags a_neg/b_neg at operation start;
//        hi_raw/lo_raw -> hi_fix/lo_fix using the recorded signs neg_a/neg_b at completion.
`ifdef MDU_SIGNED_EN
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic             op_signed,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] a_mag,
    output logic [WIDTH-1:0] b_mag,
    output logic             a_neg,
    output logic             b_neg,
    input  logic             is_div,
    input  logic             neg_a,
    input  logic             neg_b,
    input  logic [WIDTH-1:0] hi_raw,
    input  logic [WIDTH-1:0] lo_raw,
    output logic [WIDTH-1:0] hi_fix,
    output logic [WIDTH-1:0] lo_fix
);

    logic [2*WIDTH-1:0] prod_neg;

    assign a_neg = op_signed & a_in[WIDTH-1];
    assign b_neg = op_signed & b_in[WIDTH-1];
    assign a_mag = a_neg ? -a_in : a_in;
    assign b_mag = b_neg ? -b_in : b_in;

    // Full 64-bit negate so the borrow propagates from lo into hi.
    assign prod_neg = -{hi_raw, lo_raw};

    always_comb begin
        hi_fix = hi_raw;
        lo_fix = lo_raw;
        if (is_div) begin
            // quotient sign = sign(a)^sign(b); remainder follows the dividend
            lo_fix = (neg_a ^ neg_b) ? -lo_raw : lo_raw;
            hi_fix = neg_a ? -hi_raw : hi_raw;
        end else if (neg_a ^ neg_b) begin
            {hi_fix, lo_fix} = prod_neg;
        end
    end

endmodule
`endif

// File: rtl/mdu_seq.sv
// mdu_seq: iterative MULT/MULTU/DIV/DIVU sequencer driving an external ALU, results in hi/lo.
// Latency: start sampled in cycle 0, done pulse with valid hi/lo in cycle 33, next start in cycle 34.
// Backpressure: start is accepted only in IDLE; start while busy or in FIN is ignored.
// Ports: clk/reset (sync, active-high); start/op/rs_val/rt_val request; busy/done/hi/lo status;
//        alu_a/alu_b/alu_ctrl drive the external ALU, alu_result returns its combinational result.
// Optional: define MDU_SIGNED_EN to make op 2/3 signed; otherwise op[1] is ignored.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result
);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    // acc: product high half (MUL) or partial remainder (DIV)
    // mq : multiplier shifting out / product low half (MUL) or quotient (DIV)
    // opnd: multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0]   acc, mq, opnd;
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic [WIDTH-1:0]   acc_nx, mq_nx;
    logic [WIDTH-1:0]   sh_rem, mul_sum;
    logic               take, carry;
    logic               last, accept;
    logic [WIDTH-1:0]   a_mag, b_mag, hi_fix, lo_fix;

    assign last   = (cnt == CNT_W'(ITER_COUNT - 1));
    assign accept = (state == S_IDLE) && start;
    assign hi     = hi_r;
    assign lo     = lo_r;

`ifdef MDU_SIGNED_EN
    logic sgn_a, sgn_b, a_neg, b_neg;

    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .op_signed (op[1]),
        .a_in      (rs_val),
        .b_in      (rt_val),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .is_div    (state == S_DIV),
        .neg_a     (sgn_a),
        .neg_b     (sgn_b),
        .hi_raw    (acc_nx),
        .lo_raw    (mq_nx),
        .hi_fix    (hi_fix),
        .lo_fix    (lo_fix)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sgn_a <= 1'b0;
            sgn_b <= 1'b0;
        end else if (accept) begin
            sgn_a <= a_neg;
            sgn_b <= b_neg;
        end
    end
`else
    logic unused_op_signed;

    assign unused_op_signed = op[1];
    assign a_mag  = rs_val;
    assign b_mag  = rt_val;
    assign hi_fix = acc_nx;
    assign lo_fix = mq_nx;
`endif

    // One iteration step for both algorithms, from current state and the ALU result.
    always_comb begin
        sh_rem  = {acc[WIDTH-2:0], mq[WIDTH-1]};
        // acc[MSB] is the bit shifted out of rem: if set, shifted rem exceeds any divisor
        take    = acc[WIDTH-1] | (sh_rem >= opnd);
        mul_sum = mq[0] ? alu_result : acc;
        carry   = mq[0] & (alu_result < acc);
        if (state == S_DIV) begin
            acc_nx = take ? alu_result : sh_rem;
            mq_nx  = {mq[WIDTH-2:0], take};
        end else begin
            acc_nx = {carry, mul_sum[WIDTH-1:1]};
            mq_nx  = {mul_sum[0], mq[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_AND;
        case (state)
            S_IDLE: begin
                if (start) state_nx = op[0] ? S_DIV : S_MUL;
            end
            S_MUL: begin
                busy     = 1'b1;
                alu_a    = acc;
                alu_b    = opnd;
                alu_ctrl = ALU_ADD;
                if (last) state_nx = S_FIN;
            end
            S_DIV: begin
                busy     = 1'b1;
                alu_a    = sh_rem;
                alu_b    = opnd;
                alu_ctrl = ALU_SUB;
                if (last) state_nx = S_FIN;
            end
            S_FIN: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            acc  <= '0;
            mq   <= '0;
            opnd <= '0;
            hi_r <= '0;
            lo_r <= '0;
        end else if (accept) begin
            cnt  <= '0;
            acc  <= '0;
            mq   <= op[0] ? a_mag : b_mag;
            opnd <= op[0] ? b_mag : a_mag;
        end else if (state == S_MUL || state == S_DIV) begin
            acc <= acc_nx;
            mq  <= mq_nx;
            cnt <= cnt + 1'b1;
            // Results land on entry to FIN so hi/lo are valid alongside done.
            if (last) begin
                hi_r <= hi_fix;
                lo_r <= lo_fix;
            end
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: self-checking bench for mdu_seq with a behavioural ALU and arithmetic reference.
// Latency: checks busy/done/alu_ctrl/hi/lo on every cycle 1..33 of each operation.
// Backpressure: exercises ignored restart, mid-operation reset and back-to-back starts.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy, done;
    logic [31:0] hi, lo, alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;

    always #5 clk = ~clk;

    // external ALU stand-in
    always_comb begin
        case (alu_ctrl)
            4'd4:    alu_result = alu_a + alu_b;
            4'd6:    alu_result = alu_a - alu_b;
            4'd1:    alu_result = alu_a | alu_b;
            default: alu_result = alu_a & alu_b;
        endcase
    end

    mdu_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference result {hi, lo} from plain arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic        sgn;
        logic [31:0] ma, mb, q, r;
        logic [63:0] p;
        sgn = 1'b0;
`ifdef MDU_SIGNED_EN
        sgn = o[1];
`endif
        if (!o[0]) begin
            if (sgn) p = longint'($signed(a)) * longint'($signed(b));
            else     p = {32'h0, a} * {32'h0, b};
            return p;
        end
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        q  = (mb == 0) ? 32'hFFFF_FFFF : ma / mb;
        r  = (mb == 0) ? ma : ma % mb;
        if (sgn && (a[31] ^ b[31])) q = -q;
        if (sgn && a[31])           r = -r;
        return {r, q};
    endfunction

    // Issue one operation and check every cycle up to the done cycle (33).
    // restart_cyc: cycle to pulse an ignored start; rst_cyc: cycle to assert reset (-1 = none).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int restart_cyc, input int rst_cyc);
        logic [63:0] r;
        bit          aborted;
        logic [31:0] want_ctrl;
        r       = model(o, a, b);
        aborted = 0;
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == restart_cyc) begin
                start  = 1'b1;
                op     = ~o;
                rs_val = $urandom;
                rt_val = $urandom;
            end
            if (c == restart_cyc + 1) start = 1'b0;
            if (c == rst_cyc + 1) begin
                reset   = 1'b0;
                aborted = 1;
                exp_hi  = 32'h0;
                exp_lo  = 32'h0;
            end
            if (aborted) begin
                chk("busy_after_reset", 32'(busy), 32'h0);
                chk("done_after_reset", 32'(done), 32'h0);
                chk("ctrl_after_reset", 32'(alu_ctrl), 32'h0);
                chk("hi_after_reset", hi, exp_hi);
                chk("lo_after_reset", lo, exp_lo);
            end else begin
                want_ctrl = (c == 33) ? 32'd0 : (o[0] ? 32'd6 : 32'd4);
                chk("busy", 32'(busy), 32'h1);
                chk("done", 32'(done), (c == 33) ? 32'h1 : 32'h0);
                chk("alu_ctrl", 32'(alu_ctrl), want_ctrl);
                if (c == 33) begin
                    exp_hi = r[63:32];
                    exp_lo = r[31:0];
                    chk("alu_a_fin", alu_a, 32'h0);
                end
                chk("hi", hi, exp_hi);
                chk("lo", lo, exp_lo);
            end
            if (c == rst_cyc) reset = 1'b1;
        end
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 2'd0;
        rs_val = 32'h0;
        rt_val = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'h0);
        reset = 1'b0;

        run_op(2'd0, 32'd7, 32'd6, -1, -1);
        chk("multu_7x6_hi", hi, 32'h0000_0000);
        chk("multu_7x6_lo", lo, 32'h0000_002A);

        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        chk("multu_max_hi", hi, 32'hFFFF_FFFE);
        chk("multu_max_lo", lo, 32'h0000_0001);

        run_op(2'd1, 32'd100, 32'd7, -1, -1);
        chk("divu_100_7_lo", lo, 32'd14);
        chk("divu_100_7_hi", hi, 32'd2);

        run_op(2'd1, 32'd5, 32'd0, -1, -1);
        chk("divu_by0_lo", lo, 32'hFFFF_FFFF);
        chk("divu_by0_hi", hi, 32'd5);

        // restart pulse at cycle 10 must be ignored
        run_op(2'd0, 32'h1234_5678, 32'h0000_9ABC, 10, -1);
        // reset at cycle 15 aborts the divide with no done
        run_op(2'd1, 32'd1000, 32'd3, -1, 15);
        // immediately following: start in cycle 34 after done
        run_op(2'd1, 32'hDEAD_BEEF, 32'd13, -1, -1);
        run_op(2'd0, 32'd3, 32'd5, -1, -1);
        chk("b2b_lo", lo, 32'd15);

        run_op(2'd2, 32'd7, 32'd6, -1, -1);
        chk("op2_7x6_lo", lo, 32'd42);
`ifdef MDU_SIGNED_EN
        run_op(2'd2, -32'sd6, 32'd7, -1, -1);
        chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo", lo, 32'hFFFF_FFD6);
        run_op(2'd3, -32'sd7, 32'd2, -1, -1);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);
`endif

        for (int i = 0; i < 20; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            run_op(ro, ra, rb, -1, -1);
        end

        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_ctrl", 32'(alu_ctrl), 32'h0);
        chk("hold_hi", hi, exp_hi);
        chk("hold_lo", lo, exp_lo);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
